// File: rtl/jt900h_div_unit.sv
// jt900h_div_unit
//   Multi-cycle restoring divider that answers the ALU divide handshake for
//   DIV/DIVS in byte (16/8) and word (32/16) forms.
//
//   Ports
//     clk    in   1   system clock
//     rst    in   1   asynchronous reset, active-low
//     cen    in   1   clock enable; state only advances on clk edges with cen=1
//     op0    in  32   dividend (word: [31:0], byte: [15:0])
//     op1    in  16   divisor  (word: [15:0], byte: [7:0])
//     len    in   1   1 = word, 0 = byte
//     sign   in   1   1 = signed (DIVS), 0 = unsigned (DIV)
//     start  in   1   request, sampled on cen edges while idle
//     quot   out 16   quotient  (byte mode: [15:8] = 0)
//     rem    out 16   remainder (byte mode: [15:8] = 0)
//     busy   out  1   high from acceptance until the result is valid
//     v      out  1   overflow / divide-by-zero
//
//   Optional build macro
//     JT900H_DIV_RADIX4_EN : retire two quotient bits per cen edge.
//                            Results are identical; only latency changes.

module jt900h_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        sign,
  input  logic        start,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        busy,
  output logic        v
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_reg;
  logic [15:0] pr_reg;     // partial remainder (always < divisor)
  logic [15:0] ql_reg;     // dividend low bits shifting out, quotient bits shifting in
  logic [15:0] dvs_reg;    // divisor magnitude
  logic [15:0] lo_reg;     // dividend low half magnitude, reported on overflow
  logic [4:0]  cnt_reg;
  logic        len_reg;
  logic        sign_reg;
  logic        negq_reg;
  logic        negr_reg;
  logic        early_reg;

  // One restoring step: shift {pr, ql} left, trial-subtract the divisor.
  // pr < dvs keeps the 17-bit shifted value below 2*dvs, so bit 16 of the
  // difference is a clean borrow indicator.
  function automatic logic [31:0] div_step(input logic [15:0] pr,
                                           input logic [15:0] ql,
                                           input logic [15:0] dvs);
    logic [16:0] sh;
    logic [16:0] diff;
    sh   = {pr, ql[15]};
    diff = sh - {1'b0, dvs};
    if (!diff[16])
      div_step = {diff[15:0], ql[14:0], 1'b1};
    else
      div_step = {sh[15:0], ql[14:0], 1'b0};
  endfunction

  // ---------------- operand preparation (used on acceptance) -------------
  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic [15:0] upper_mag;
  logic        early_ovf;
  logic [4:0]  cnt_init;

  always_comb begin
    dvd_neg = sign & (len ? op0[31] : op0[15]);
    dvs_neg = sign & (len ? op1[15] : op1[7]);
    dvd_mag = 32'd0;
    dvs_mag = 16'd0;
    if (len) begin
      dvd_mag = dvd_neg ? (~op0 + 32'd1) : op0;
      dvs_mag = dvs_neg ? (~op1 + 16'd1) : op1;
    end else begin
      dvd_mag[15:0] = dvd_neg ? (~op0[15:0] + 16'd1) : op0[15:0];
      dvs_mag[7:0]  = dvs_neg ? (~op1[7:0] + 8'd1) : op1[7:0];
    end
    upper_mag = len ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    early_ovf = (dvs_mag == 16'd0) || (upper_mag >= dvs_mag);
`ifdef JT900H_DIV_RADIX4_EN
    cnt_init  = len ? 5'd8 : 5'd4;
`else
    cnt_init  = len ? 5'd16 : 5'd8;
`endif
  end

  // ---------------- iteration datapath -----------------------------------
  logic [31:0] step_a;
  logic [31:0] run_next;

  always_comb begin
    step_a = div_step(pr_reg, ql_reg, dvs_reg);
`ifdef JT900H_DIV_RADIX4_EN
    run_next = div_step(step_a[31:16], step_a[15:0], dvs_reg);
`else
    run_next = step_a;
`endif
  end

  // ---------------- result fix-up ----------------------------------------
  logic [15:0] q_mag;
  logic [15:0] q_signed;
  logic [15:0] r_signed;
  logic        signed_ovf;
  logic        ovf;
  logic [15:0] quot_fix;
  logic [15:0] rem_fix;

  always_comb begin
    // In byte mode the dividend bits are pre-aligned to the top of ql_reg,
    // so after 8 steps the quotient sits in [7:0] with zeros above.
    q_mag = len_reg ? ql_reg : {8'h00, ql_reg[7:0]};
    if (len_reg)
      signed_ovf = negq_reg ? (q_mag > 16'h8000) : (q_mag > 16'h7FFF);
    else
      signed_ovf = negq_reg ? (q_mag > 16'h0080) : (q_mag > 16'h007F);
    ovf      = early_reg | (sign_reg & signed_ovf);
    q_signed = negq_reg ? (~q_mag + 16'd1) : q_mag;
    r_signed = negr_reg ? (~pr_reg + 16'd1) : pr_reg;
    if (ovf) begin
      quot_fix = 16'hFFFF;
      rem_fix  = lo_reg;
    end else begin
      quot_fix = q_signed;
      rem_fix  = r_signed;
    end
    if (!len_reg) begin
      quot_fix[15:8] = 8'h00;
      rem_fix[15:8]  = 8'h00;
    end
  end

  // ---------------- control FSM and registered outputs -------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pr_reg    <= 16'd0;
      ql_reg    <= 16'd0;
      dvs_reg   <= 16'd0;
      lo_reg    <= 16'd0;
      cnt_reg   <= 5'd0;
      len_reg   <= 1'b0;
      sign_reg  <= 1'b0;
      negq_reg  <= 1'b0;
      negr_reg  <= 1'b0;
      early_reg <= 1'b0;
      quot      <= 16'd0;
      rem       <= 16'd0;
      busy      <= 1'b0;
      v         <= 1'b0;
    end else if (cen) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg   <= len;
            sign_reg  <= sign;
            negq_reg  <= dvd_neg ^ dvs_neg;
            negr_reg  <= dvd_neg;
            dvs_reg   <= dvs_mag;
            pr_reg    <= upper_mag;
            ql_reg    <= len ? dvd_mag[15:0] : {dvd_mag[7:0], 8'h00};
            lo_reg    <= len ? dvd_mag[15:0] : {8'h00, dvd_mag[7:0]};
            early_reg <= early_ovf;
            busy      <= 1'b1;
            if (early_ovf) begin
              state_reg <= FIX;
            end else begin
              cnt_reg   <= cnt_init;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          pr_reg  <= run_next[31:16];
          ql_reg  <= run_next[15:0];
          cnt_reg <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1)
            state_reg <= FIX;
        end
        FIX: begin
          quot      <= quot_fix;
          rem       <= rem_fix;
          v         <= ovf;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/jt900h_div_unit.md
Name: jt900h_div_unit

Overview:
Multi-cycle restoring divider. It is the responder side of the ALU's divide handshake. The ALU drives dividend, divisor, length, sign and a start pulse; the block holds busy while iterating, then presents quotient, remainder and overflow. It serves the DIV/DIVS instructions in byte (16/8) and word (32/16) forms.

Parameters:
None.

Ports:
clk    in   1   system clock
rst    in   1   asynchronous reset, active-low
cen    in   1   clock enable; all state advances only on clk edges with cen=1
op0    in   32  dividend; word mode uses [31:0], byte mode uses [15:0]
op1    in   16  divisor; word mode uses [15:0], byte mode uses [7:0]
len    in   1   1 = word (32/16), 0 = byte (16/8)
sign   in   1   1 = signed (DIVS), 0 = unsigned (DIV)
start  in   1   request; sampled on cen edges in IDLE
quot   out  16  quotient; byte mode uses [7:0], [15:8] forced to 0
rem    out  16  remainder; byte mode uses [7:0], [15:8] forced to 0
busy   out  1   high from the cen edge that accepts start until the result is valid
v      out  1   overflow / divide-by-zero flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, quot=0, rem=0, busy=0, v=0, counter=0.
- N = 16 in word mode, 8 in byte mode.
- States: IDLE, RUN, FIX.
- IDLE + start on a cen edge:
  - Latch len and sign.
  - Latch the dividend and divisor magnitudes; when sign=1, take two's-complement absolute values.
  - Record neg_q = sign of dividend XOR sign of divisor, and neg_r = sign of dividend.
  - busy goes 1 on this same edge.
  - If divisor==0, or the upper-half magnitude of the dividend is >= the divisor magnitude: set the early-overflow flag and go to FIX.
  - Otherwise: counter=N, go to RUN.
- RUN: each cen edge does one restoring step.
  - Shift {partial remainder, dividend low} left by 1.
  - Trial-subtract the divisor; the quotient bit is 1 when the subtraction does not borrow.
  - Decrement counter; go to FIX when it reaches 0.
  - Busy time in RUN is N cen edges.
- FIX: one cen edge, then return to IDLE with busy=0.
  - Early overflow: v=1, quot = all ones in width (0xFF or 0xFFFF), rem = dividend low half.
  - Signed mode: overflow if the magnitude quotient is > 2^(N-1)-1 with neg_q=0, or > 2^(N-1) with neg_q=1. Then v=1, quot = all ones, rem = dividend low half.
  - Otherwise: v=0. Quotient is negated if neg_q; remainder is negated if neg_r. The remainder takes the dividend's sign and |rem| < |divisor|.
- Total busy duration: N+1 cen edges normally, 1 cen edge on early overflow.
- Outputs are registered. quot/rem/v keep their values until the FIX of the next operation; they are not cleared at start.
- start while busy=1 is ignored; in-flight inputs may change freely after acceptance.
- start held high across the return to IDLE is accepted again on the next cen edge in IDLE.
- cen=0 freezes all state, including busy.
- Reset asserted mid-operation aborts immediately to the reset values.

Optional Feature:
JT900H_DIV_RADIX4_EN
- Defined: RUN retires two quotient bits per cen edge (two cascaded restoring steps) and counter starts at N/2. Busy lasts N/2+1 cen edges (9 word, 5 byte). Results and flags are bit-identical to the undefined build.
- Undefined: one bit per cen edge, as described above.

Test Plan:
1. Unsigned word: len=1, sign=0, op0=0x00123456, op1=0x1234 -> quot=0x0100, rem=0x0056, v=0; busy high exactly 17 cen edges.
2. Unsigned byte: len=0, op0=0x0064, op1=0x0007 -> quot=0x000E, rem=0x0002, v=0; busy 9 edges. Repeat with cen toggling every other clk -> busy spans 18 clk cycles.
3. Signed byte cases, all v=0:
   - op0=0xFF9C (-100), op1=0x07 -> quot=0x00F2, rem=0x00FE.
   - op0=0x0064, op1=0xF9 -> quot=0x00F2, rem=0x0002.
4. Divide by zero: len=1, op0=0xABCD1234, op1=0 -> v=1, quot=0xFFFF, rem=0x1234; busy 1 edge. Upper-half overflow: len=0, sign=0, op0=0x1000, op1=0x10 -> v=1, quot=0x00FF, rem=0x0000.
5. Signed late overflow:
   - len=0, sign=1, op0=0xFF80, op1=0xFF (-128/-1) -> v=1, quot=0x00FF, rem=0x0080.
   - op0=0xFF80, op1=0x01 -> v=0, quot=0x0080, rem=0x0000.
6. Protocol and reset:
   - Pulse start again mid-RUN with different operands -> ignored; first result unchanged.
   - Drop rst mid-RUN -> busy, quot, rem and v are 0 asynchronously.
   - Next start after reset completes normally.
